// File: rtl/hlsm_arbiter.sv
// hlsm_arbiter: round-robin front end that shares one HLSM counter core among
// NREQ requesters. Each grant runs go -> wait for done (or watchdog abort) ->
// one-cycle acknowledge carrying the captured core count.
module hlsm_arbiter #(
  parameter int NREQ    = 4,
  parameter int CW      = 5,
  parameter int TIMEOUT = 64
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [NREQ-1:0] ack,
  output logic            err,
  output logic [CW-1:0]   result,
  output logic            busy,
  output logic            core_go,
  output logic            core_rst,
  input  logic [CW-1:0]   core_count,
  input  logic            core_done
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
  localparam logic [PW-1:0] PLAST = PW'(NREQ - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    FIN   = 2'd3
  } state_t;

  state_t          state_r, state_s;
  logic [NREQ-1:0] gnt_r, gnt_s;
  logic [NREQ-1:0] ack_r, ack_s;
  logic            err_r, err_s;
  logic [CW-1:0]   result_r, result_s;
  logic            busy_r, busy_s;
  logic            core_go_r, core_go_s;
  logic            core_rst_r, core_rst_s;
  logic [PW-1:0]   ptr_r, ptr_s;
  logic [PW-1:0]   gidx_r, gidx_s;
  logic [TW-1:0]   timer_r, timer_s;
  logic            abort_r, abort_s;

  logic            pick_found_s;
  logic [PW-1:0]   pick_idx_s;
  logic [NREQ-1:0] pick_oh_s;

  // First set request bit scanning upward from p, wrapping modulo NREQ.
  // Returns {found, index}.
  function automatic logic [PW:0] rr_pick(input logic [NREQ-1:0] r,
                                          input logic [PW-1:0]   p);
    int            j;
    logic          found;
    logic [PW-1:0] idx;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      j = (int'(p) + i) % NREQ;
      if (!found && r[j]) begin
        found = 1'b1;
        idx   = PW'(j);
      end else begin
        idx   = idx;
      end
    end
    return {found, idx};
  endfunction

  assign {pick_found_s, pick_idx_s} = rr_pick(req, ptr_r);
  assign pick_oh_s = {{(NREQ-1){1'b0}}, 1'b1} << pick_idx_s;

  // Next-state and next-output logic; pulses default low every cycle.
  always_comb begin
    state_s    = state_r;
    gnt_s      = gnt_r;
    busy_s     = busy_r;
    ack_s      = '0;
    err_s      = 1'b0;
    core_go_s  = 1'b0;
    core_rst_s = 1'b0;
    result_s   = result_r;
    ptr_s      = ptr_r;
    gidx_s     = gidx_r;
    timer_s    = timer_r;
    abort_s    = abort_r;
    case (state_r)
      IDLE: begin
        if (pick_found_s) begin
          gnt_s   = pick_oh_s;
          busy_s  = 1'b1;
          gidx_s  = pick_idx_s;
          state_s = START;
        end else begin
          gnt_s   = '0;
          busy_s  = 1'b0;
          state_s = IDLE;
        end
      end
      START: begin
        timer_s   = '0;
        core_go_s = 1'b1;
        state_s   = WAIT;
      end
      WAIT: begin
        timer_s = timer_r + TW'(1);
        // done takes priority over a coincident watchdog expiry
        if (core_done) begin
          result_s = core_count;
          state_s  = FIN;
        end else if (timer_r == TLAST) begin
          core_rst_s = 1'b1;
          abort_s    = 1'b1;
          state_s    = FIN;
        end else begin
          state_s = WAIT;
        end
      end
      FIN: begin
        ack_s   = gnt_r;
        err_s   = abort_r;
        ptr_s   = (gidx_r == PLAST) ? '0 : gidx_r + PW'(1);
        gnt_s   = '0;
        busy_s  = 1'b0;
        abort_s = 1'b0;
        state_s = IDLE;
      end
      default: begin
        gnt_s   = '0;
        busy_s  = 1'b0;
        abort_s = 1'b0;
        state_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Registered outputs and datapath (pointer, timer, abort flag).
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      gnt_r      <= '0;
      ack_r      <= '0;
      err_r      <= 1'b0;
      result_r   <= '0;
      busy_r     <= 1'b0;
      core_go_r  <= 1'b0;
      core_rst_r <= 1'b0;
      ptr_r      <= '0;
      gidx_r     <= '0;
      timer_r    <= '0;
      abort_r    <= 1'b0;
    end else begin
      gnt_r      <= gnt_s;
      ack_r      <= ack_s;
      err_r      <= err_s;
      result_r   <= result_s;
      busy_r     <= busy_s;
      core_go_r  <= core_go_s;
      core_rst_r <= core_rst_s;
      ptr_r      <= ptr_s;
      gidx_r     <= gidx_s;
      timer_r    <= timer_s;
      abort_r    <= abort_s;
    end
  end

  assign gnt      = gnt_r;
  assign ack      = ack_r;
  assign err      = err_r;
  assign result   = result_r;
  assign busy     = busy_r;
  assign core_go  = core_go_r;
  assign core_rst = core_rst_r;

endmodule

// File: doc/hlsm_arbiter.md
Name: hlsm_arbiter

Overview:
Round-robin arbiter and sequencer that shares one HLSM counter core among NREQ requesters. For each granted requester it issues a single-cycle go pulse to the core and waits for core done. It then captures the core count and returns a one-cycle acknowledge. A watchdog aborts a stuck core by pulsing a core reset and flagging an error.

Parameters:
NREQ, 4, number of requesters (2..8)
CW, 5, width of core count / result
TIMEOUT, 64, maximum WAIT cycles before abort (>=2)

Ports:
Clk  input  1  system clock, rising edge
Rst  input  1  reset: asynchronous, active-high; also drives the shared HLSM core
req  input  NREQ  per-requester level request
gnt  output  NREQ  one-hot grant, held for the whole transaction
ack  output  NREQ  one-cycle completion pulse to the granted requester
err  output  1  one-cycle pulse coincident with ack when the transaction timed out
result  output  CW  core count captured at completion
busy  output  1  high from grant until return to IDLE
core_go  output  1  start pulse to the HLSM core
core_rst  output  1  one-cycle abort reset to the core (ORed with Rst externally)
core_count  input  CW  HLSM core count output
core_done  input  1  HLSM core done (level)

Behaviour:
- All outputs are registered. The state machine has four states: IDLE, START, WAIT, FIN.
- Async reset (Rst=1) values: state=IDLE, gnt=0, ack=0, err=0, result=0, busy=0, core_go=0, core_rst=0, rr pointer ptr=0, timer=0.
- Reset applies immediately at any point, including mid-transaction. The aborted requester receives no ack.
- IDLE:
  - If req!=0, select the first set bit scanning ptr, ptr+1, ... wrapping modulo NREQ.
  - Set gnt to that one-hot value and busy=1, then go to START.
  - Otherwise stay in IDLE with gnt=0.
- START:
  - core_go=1 for exactly this one cycle.
  - timer is cleared.
  - Go to WAIT.
- WAIT:
  - timer increments by 1 each cycle, with width clog2(TIMEOUT).
  - If core_done=1: result<=core_count, then go to FIN with normal completion.
  - Else if timer==TIMEOUT-1: core_rst=1 for one cycle, set the internal abort flag, then go to FIN. result is unchanged.
  - core_done wins if it rises in the same cycle as the timeout.
- FIN:
  - ack=gnt for this one cycle.
  - err=abort flag for this one cycle.
  - ptr <= (granted index + 1) mod NREQ.
  - Go to IDLE. On entry to IDLE, gnt, busy and the abort flag are cleared.
- core_done outside WAIT is ignored.
- req changes during START/WAIT/FIN are ignored. The granted transaction always completes.
- A requester still asserting req after its ack is re-arbitrated at lowest round-robin priority.
- Timing:
  - Minimum transaction is 4 cycles (IDLE→START→WAIT→FIN), i.e. core_done in the first WAIT cycle.
  - Grant appears 1 cycle after req is seen in IDLE.
  - core_go appears 1 cycle after grant.
- Only one of gnt/ack bits is ever set. gnt and ack are one-hot or zero.

Test Plan:
- Reset: Rst=1 for 2 cycles with req=4'b1111 → all outputs 0. After release, the first grant is gnt=4'b0001.
- Single request: req=4'b0100, core_done after 5 WAIT cycles, core_count=5'd17.
  - gnt=4'b0100 held.
  - core_go high exactly 1 cycle.
  - ack=4'b0100 for 1 cycle with result=17, err=0, busy low the next cycle.
- Round-robin: req=4'b1111 held, core_done on the first WAIT cycle each time → grant order 0,1,2,3,0. Each transaction takes 4 cycles.
- Timeout: TIMEOUT=8, core_done held 0.
  - core_rst pulses 1 cycle on the 8th WAIT cycle.
  - Next cycle: ack=gnt with err=1; result keeps its previous value.
- Tie: TIMEOUT=8, core_done=1 in the 8th WAIT cycle with core_count=5'd9 → normal completion, err=0, core_rst never asserted, result=9.
- Reset mid-WAIT: assert Rst while gnt=4'b0010.
  - gnt, busy and core_go drop immediately; no ack.
  - After release with req=4'b1001, gnt=4'b0001 (ptr reset to 0).
